cpu_run_ctrl: RTL

Run/halt/step controller that sequences the 8-bit cpu core through a per-cycle execute enable and a soft reset. A host issues commands over a valid/ready port: run, halt, step N, set/clear breakpoint, soft reset. The controller compares the CPU instruction pointer against a breakpoint, counts executed cycles and reports why the CPU stopped. It sits between the cpu core and the host/testbench, replacing free-running clock pulsing.

---
 rtl/cpu_run_ctrl_pkg.sv | 31 +++
 rtl/cpu_run_ctrl_sat_counter.sv | 26 ++
 rtl/cpu_run_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run/halt/step controller: host opcodes,
// stop reasons and controller states.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_RUN      = 3'd1,
    OP_HALT     = 3'd2,
    OP_STEP     = 3'd3,
    OP_SET_BP   = 3'd4,
    OP_CLR_BP   = 3'd5,
    OP_SOFT_RST = 3'd6,
    OP_NOP7     = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    SR_RESET     = 3'd0,
    SR_HOST      = 3'd1,
    SR_BREAK     = 3'd2,
    SR_STEP_DONE = 3'd3,
    SR_CPU_HLT   = 3'd4
  } stop_reason_e;

  typedef enum logic [1:0] {
    ST_RST_SEQ,
    ST_HALTED,
    ST_RUN,
    ST_STEP
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller: gates the CPU execute enable, sequences soft
// reset, checks a single breakpoint and records why execution stopped.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic [ADDR_W-1:0] ip,
  input  logic              cpu_hlt,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              running,
  output logic [2:0]        stop_reason,
  output logic [ADDR_W-1:0] bp_addr,
  output logic              bp_valid,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_e            r_state, w_next_state;
  stop_reason_e      r_stop_reason, w_stop_nxt;
  logic [RC_W-1:0]   r_rst_cnt;
  logic [7:0]        r_step_cnt;
  logic              r_skip_bp;
  logic              r_bp_valid;
  logic [ADDR_W-1:0] r_bp_addr;
  logic              r_running;

  logic    w_accept, w_cpu_en, w_bp_block;
  cmd_op_e w_op;
  logic    w_soft, w_run, w_halt, w_step, w_set_bp, w_clr_bp;

  assign cmd_ready  = (r_state != ST_RST_SEQ);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_op       = cmd_op_e'(cmd_op);
  assign w_soft     = w_accept && (w_op == OP_SOFT_RST);
  assign w_run      = w_accept && (w_op == OP_RUN);
  assign w_halt     = w_accept && (w_op == OP_HALT);
  assign w_step     = w_accept && (w_op == OP_STEP);
  assign w_set_bp   = w_accept && (w_op == OP_SET_BP);
  assign w_clr_bp   = w_accept && (w_op == OP_CLR_BP);
  // skip_bp lets a resumed run leave an ip that is parked on the breakpoint.
  assign w_bp_block = r_bp_valid && (ip == r_bp_addr) && !r_skip_bp;

  always_comb begin
    w_next_state = r_state;
    w_stop_nxt   = r_stop_reason;
    w_cpu_en     = 1'b0;
    case (r_state)
      ST_RST_SEQ: begin
        if (r_rst_cnt == RC_LAST) begin
          w_next_state = ST_HALTED;
          w_stop_nxt   = SR_RESET;
        end
      end
      ST_HALTED: begin
        if (w_soft) begin
          w_next_state = ST_RST_SEQ;
          w_stop_nxt   = SR_RESET;
        end else if (w_run && !cpu_hlt) begin
          w_next_state = ST_RUN;
        end else if (w_step && !cpu_hlt) begin
          w_next_state = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        // Ordered by stop priority; only a clean cycle executes.
        if (w_soft) begin
          w_next_state = ST_RST_SEQ;
          w_stop_nxt   = SR_RESET;
        end else if (cpu_hlt) begin
          w_next_state = ST_HALTED;
          w_stop_nxt   = SR_CPU_HLT;
        end else if (w_bp_block) begin
          w_next_state = ST_HALTED;
          w_stop_nxt   = SR_BREAK;
        end else if (w_halt) begin
          w_next_state = ST_HALTED;
          w_stop_nxt   = SR_HOST;
        end else begin
          w_cpu_en = 1'b1;
          if ((r_state == ST_STEP) && (r_step_cnt == 8'd1)) begin
            w_next_state = ST_HALTED;
            w_stop_nxt   = SR_STEP_DONE;
          end
        end
      end
      default: begin
        w_next_state = ST_RST_SEQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RST_SEQ;
      r_stop_reason <= SR_RESET;
      r_rst_cnt     <= '0;
      r_step_cnt    <= '0;
      r_skip_bp     <= 1'b0;
      r_bp_valid    <= 1'b0;
      r_bp_addr     <= '0;
      r_running     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_stop_reason <= w_stop_nxt;
      r_running     <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP);

      if ((r_state == ST_RST_SEQ) && (w_next_state == ST_RST_SEQ)) begin
        r_rst_cnt <= r_rst_cnt + 1'b1;
      end else begin
        r_rst_cnt <= '0;
      end

      if ((r_state == ST_HALTED) && (w_next_state != ST_HALTED) &&
          (w_next_state != ST_RST_SEQ)) begin
        r_skip_bp <= 1'b1;
      end else if (w_cpu_en) begin
        r_skip_bp <= 1'b0;
      end

      if ((r_state == ST_HALTED) && (w_next_state == ST_STEP)) begin
        r_step_cnt <= (cmd_data == 8'd0) ? 8'd1 : cmd_data;
      end else if (w_cpu_en && (r_state == ST_STEP)) begin
        r_step_cnt <= r_step_cnt - 1'b1;
      end

      if (w_set_bp) begin
        r_bp_addr  <= ADDR_W'(cmd_data);
        r_bp_valid <= 1'b1;
      end else if (w_clr_bp) begin
        r_bp_valid <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_soft),
    .i_inc (w_cpu_en),
    .o_cnt (cycle_cnt)
  );

  assign cpu_en      = w_cpu_en;
  assign cpu_rst_n   = (r_state != ST_RST_SEQ);
  assign running     = r_running;
  assign stop_reason = r_stop_reason;
  assign bp_addr     = r_bp_addr;
  assign bp_valid    = r_bp_valid;

endmodule
